// File: rtl/fwd_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : fwd_scoreboard_if
// Description : Bundle of decode-side signals between the pipeline control
//               and the forwarding scoreboard.
//               master : pipeline/decode side (drives issue, selects, data)
//               slave  : fwd_scoreboard (returns operands, hits, stall)
//   advance      pipeline moves this cycle
//   flush        squash youngest tracked entry and the issuing instruction
//   issue_*      decode instruction descriptor (valid, wen, wsel, ld)
//   rsel         NRD packed read selects
//   rf_data      NRD packed register file read words
//   stage_data   DEPTH packed result words, index 0 = EX
//   fwd_data     NRD packed resolved operands
//   fwd_hit      per-port "resolved from stage_data"
//   stall        hold decode, bubble into EX
//   perf_*       event counters (present only with FWD_PERF_EN)
// Optional    : FWD_PERF_EN adds perf_fwd_cnt / perf_stall_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
interface fwd_scoreboard_if #(
    parameter int NREGS  = 32,
    parameter int REG_W  = $clog2(NREGS),
    parameter int WORD_W = 32,
    parameter int DEPTH  = 3,
    parameter int NRD    = 2
);
    logic                    advance;
    logic                    flush;
    logic                    issue_valid;
    logic                    issue_wen;
    logic [REG_W-1:0]        issue_wsel;
    logic                    issue_ld;
    logic [NRD*REG_W-1:0]    rsel;
    logic [NRD*WORD_W-1:0]   rf_data;
    logic [DEPTH*WORD_W-1:0] stage_data;
    logic [NRD*WORD_W-1:0]   fwd_data;
    logic [NRD-1:0]          fwd_hit;
    logic                    stall;
`ifdef FWD_PERF_EN
    logic [31:0]             perf_fwd_cnt;
    logic [31:0]             perf_stall_cnt;
`endif

    modport master (
        output advance, flush, issue_valid, issue_wen, issue_wsel, issue_ld,
        output rsel, rf_data, stage_data,
        input  fwd_data, fwd_hit, stall
`ifdef FWD_PERF_EN
        , input perf_fwd_cnt, perf_stall_cnt
`endif
    );

    modport slave (
        input  advance, flush, issue_valid, issue_wen, issue_wsel, issue_ld,
        input  rsel, rf_data, stage_data,
        output fwd_data, fwd_hit, stall
`ifdef FWD_PERF_EN
        , output perf_fwd_cnt, perf_stall_cnt
`endif
    );
endinterface
`default_nettype wire

// File: rtl/fwd_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : fwd_scoreboard
// Description : Parametrised operand forwarding / load-use hazard unit.
//               Tracks in-flight register writes over DEPTH post-decode
//               stages (0 = EX, youngest) and resolves NRD decode read
//               ports against them. The youngest matching producer wins;
//               if it is a load whose data is not yet in stage_data, a
//               stall is raised instead of forwarding.
// Ports       : CLK  - clock
//               RST  - synchronous active-high reset
//               bus  - fwd_scoreboard_if.slave (issue, selects, data in;
//                      fwd_data, fwd_hit, stall out)
// Optional    : `define FWD_PERF_EN to add saturating 32-bit counters
//               perf_fwd_cnt and perf_stall_cnt on the interface.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_scoreboard #(
    parameter int NREGS    = 32,
    parameter int REG_W    = $clog2(NREGS),
    parameter int WORD_W   = 32,
    parameter int DEPTH    = 3,
    parameter int NRD      = 2,
    parameter int LD_STAGE = 1
) (
    input  logic              CLK,
    input  logic              RST,
    fwd_scoreboard_if.slave   bus
);

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] wsel;
        logic             ld;
    } entry_t;

    entry_t                r_ent [DEPTH];
    logic   [DEPTH-1:0]    w_ready;
    logic   [NRD-1:0]      w_stall_req;
    logic   [NRD-1:0]      w_hit;
    logic   [NRD*WORD_W-1:0] w_fwd_data;
    logic                  w_stall;
    entry_t                w_new_entry;

    // Register 0 is hardwired zero, so writes to it are never tracked.
    assign w_new_entry.valid = bus.issue_valid & bus.issue_wen & (bus.issue_wsel != '0);
    assign w_new_entry.wsel  = bus.issue_wsel;
    assign w_new_entry.ld    = bus.issue_ld;

    // A load's value appears in stage_data only from LD_STAGE onward.
    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_ready
            if (k >= LD_STAGE) begin : g_late
                assign w_ready[k] = 1'b1;
            end else begin : g_early
                assign w_ready[k] = ~r_ent[k].ld;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Per-port resolution
    // ------------------------------------------------------------------
    generate
        for (genvar p = 0; p < NRD; p++) begin : g_port
            logic [REG_W-1:0]  sel;
            logic [WORD_W-1:0] rf_word;
            logic              found;
            logic              found_ready;
            logic [WORD_W-1:0] found_data;

            assign sel     = bus.rsel[p*REG_W +: REG_W];
            assign rf_word = bus.rf_data[p*WORD_W +: WORD_W];

            // Scan oldest to youngest so the last hit written is the
            // lowest index; an older ready producer can therefore never
            // mask a younger not-ready one.
            always_comb begin
                found       = 1'b0;
                found_ready = 1'b0;
                found_data  = '0;
                for (int k = DEPTH - 1; k >= 0; k--) begin
                    if (r_ent[k].valid && (r_ent[k].wsel == sel)) begin
                        found       = 1'b1;
                        found_ready = w_ready[k];
                        found_data  = bus.stage_data[k*WORD_W +: WORD_W];
                    end
                end
            end

            always_comb begin
                w_hit[p]                         = 1'b0;
                w_stall_req[p]                   = 1'b0;
                w_fwd_data[p*WORD_W +: WORD_W]   = rf_word;
                if ((sel != '0) && found) begin
                    if (found_ready) begin
                        w_hit[p]                       = 1'b1;
                        w_fwd_data[p*WORD_W +: WORD_W] = found_data;
                    end else begin
                        w_stall_req[p] = 1'b1;
                    end
                end
            end
        end
    endgenerate

    // A flushed or absent decode instruction cannot cause a hazard.
    assign w_stall = (|w_stall_req) & bus.issue_valid & ~bus.flush;

    assign bus.fwd_data = w_fwd_data;
    assign bus.fwd_hit  = w_hit;
    assign bus.stall    = w_stall;

    // ------------------------------------------------------------------
    // Tracked-write shift structure
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_ent[k] <= '0;
            end
        end else if (bus.advance) begin
            // On flush the old EX entry is squashed on its way into stage 1.
            for (int k = 1; k < DEPTH; k++) begin
                if (bus.flush && (k == 1)) begin
                    r_ent[k] <= '0;
                end else begin
                    r_ent[k] <= r_ent[k-1];
                end
            end
            if (bus.flush || w_stall) begin
                r_ent[0] <= '0;
            end else begin
                r_ent[0] <= w_new_entry;
            end
        end else if (bus.flush) begin
            r_ent[0].valid <= 1'b0;
        end
    end

`ifdef FWD_PERF_EN
    // ------------------------------------------------------------------
    // Saturating event counters
    // ------------------------------------------------------------------
    logic [31:0] r_perf_fwd;
    logic [31:0] r_perf_stall;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_perf_fwd   <= '0;
            r_perf_stall <= '0;
        end else if (bus.advance) begin
            if ((|w_hit) && (r_perf_fwd != 32'hFFFF_FFFF)) begin
                r_perf_fwd <= r_perf_fwd + 32'd1;
            end
            if (w_stall && (r_perf_stall != 32'hFFFF_FFFF)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign bus.perf_fwd_cnt   = r_perf_fwd;
    assign bus.perf_stall_cnt = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fwd_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_fwd_scoreboard
// Description : Directed bench for fwd_scoreboard (DEPTH=3, NRD=2,
//               LD_STAGE=1). Each stimulus cycle pushes its hand-computed
//               expectation; a monitor pops and compares on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fwd_scoreboard;

    localparam logic [31:0] RF0 = 32'hF0F0_F0F0;
    localparam logic [31:0] RF1 = 32'hF1F1_F1F1;
    localparam logic [31:0] S0  = 32'hAAAA_0000;
    localparam logic [31:0] S1  = 32'hBBBB_0001;
    localparam logic [31:0] S2  = 32'hCCCC_0002;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fwd_scoreboard_if #(.NREGS(32), .WORD_W(32), .DEPTH(3), .NRD(2)) bus ();

    fwd_scoreboard #(
        .NREGS(32), .WORD_W(32), .DEPTH(3), .NRD(2), .LD_STAGE(1)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  hit;
        logic        stall;
        logic        adv;
        logic        rst;
        int          id;
    } exp_t;

    exp_t        expq[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc_id   = 0;
    logic [95:0] sd_next;

    task automatic chk(input string name, input int id, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s cycle %0d: got %h want %h", name, id, act, want);
        end
    endtask

    // One decode cycle: drive inputs just after the rising edge and queue
    // the expected combinational response for this cycle.
    task automatic cyc(input logic r, input logic adv, input logic fl,
                       input logic iv, input logic wen, input logic [4:0] ws, input logic ld,
                       input logic [4:0] r0, input logic [4:0] r1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [1:0] h, input logic st);
        exp_t e;
        @(posedge clk);
        #1;
        rst             = r;
        bus.advance     = adv;
        bus.flush       = fl;
        bus.issue_valid = iv;
        bus.issue_wen   = wen;
        bus.issue_wsel  = ws;
        bus.issue_ld    = ld;
        bus.rsel        = {r1, r0};
        bus.rf_data     = {RF1, RF0};
        bus.stage_data  = sd_next;
        e.data  = {d1, d0};
        e.hit   = h;
        e.stall = st;
        e.adv   = adv;
        e.rst   = r;
        e.id    = cyc_id;
        expq.push_back(e);
        cyc_id++;
    endtask

    // Monitor
    initial begin
        exp_t e;
        logic [31:0] m_fwd;
        logic [31:0] m_stall;
        m_fwd   = '0;
        m_stall = '0;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("fwd_data", e.id, bus.fwd_data, e.data);
                chk("fwd_hit", e.id, {62'd0, bus.fwd_hit}, {62'd0, e.hit});
                chk("stall", e.id, {63'd0, bus.stall}, {63'd0, e.stall});
`ifdef FWD_PERF_EN
                chk("perf_fwd_cnt", e.id, {32'd0, bus.perf_fwd_cnt}, {32'd0, m_fwd});
                chk("perf_stall_cnt", e.id, {32'd0, bus.perf_stall_cnt}, {32'd0, m_stall});
`endif
                if (e.rst) begin
                    m_fwd   = '0;
                    m_stall = '0;
                end else if (e.adv) begin
                    if ((|e.hit) && m_fwd != 32'hFFFF_FFFF) m_fwd = m_fwd + 1;
                    if (e.stall && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        sd_next         = {S2, S1, S0};
        bus.advance     = 1'b0;
        bus.flush       = 1'b0;
        bus.issue_valid = 1'b0;
        bus.issue_wen   = 1'b0;
        bus.issue_wsel  = '0;
        bus.issue_ld    = 1'b0;
        bus.rsel        = '0;
        bus.rf_data     = {RF1, RF0};
        bus.stage_data  = sd_next;

        //  r adv fl iv wen ws ld  r0 r1  d0   d1   hit stall
        // Reset with stale inputs; reset wins over advance and flush.
        cyc(1, 1, 0, 1, 1,  5, 0,  5, 0, RF0, RF1, 2'b00, 0);
        cyc(1, 1, 1, 1, 1,  5, 0,  5, 5, RF0, RF1, 2'b00, 0);
        cyc(0, 1, 0, 1, 1,  5, 0,  0, 0, RF0, RF1, 2'b00, 0);
        cyc(0, 1, 0, 0, 0,  0, 0,  5, 0, S0,  RF1, 2'b01, 0);
        // Back-to-back writes to $8: youngest wins on both ports.
        cyc(0, 1, 0, 1, 1,  8, 0,  0, 5, RF0, S1,  2'b10, 0);
        cyc(0, 1, 0, 1, 1,  8, 0,  0, 0, RF0, RF1, 2'b00, 0);
        sd_next = {S2, 32'h11, 32'h22};
        cyc(0, 1, 0, 0, 0,  0, 0,  8, 8, 32'h22, 32'h22, 2'b11, 0);
        sd_next = {S2, S1, S0};
        cyc(0, 1, 0, 0, 0,  0, 0,  8, 0, S1,  RF1, 2'b01, 0);
        cyc(0, 1, 0, 0, 0,  0, 0,  0, 8, RF0, S2,  2'b10, 0);
        // Load-use on $3: one stall, then forward from stage 1.
        cyc(0, 1, 0, 1, 1,  3, 1,  0, 0, RF0, RF1, 2'b00, 0);
        cyc(0, 1, 0, 1, 1,  9, 0,  3, 0, RF0, RF1, 2'b00, 1);
        cyc(0, 1, 0, 1, 1,  9, 0,  3, 3, S1,  S1,  2'b11, 0);
        // Young non-ready load must not be bypassed by an older ALU write.
        cyc(0, 1, 0, 1, 1,  4, 0,  0, 9, RF0, S0,  2'b10, 0);
        cyc(0, 1, 0, 1, 1,  4, 1,  4, 0, S0,  RF1, 2'b01, 0);
        cyc(0, 1, 0, 1, 0,  0, 0,  0, 4, RF0, RF1, 2'b00, 1);
        cyc(0, 1, 0, 1, 0,  0, 0,  0, 4, RF0, S1,  2'b10, 0);
        cyc(0, 1, 0, 0, 0,  0, 0,  4, 0, S2,  RF1, 2'b01, 0);
        // Load-use coinciding with flush: no stall, load squashed.
        cyc(0, 1, 0, 1, 1,  3, 1,  0, 0, RF0, RF1, 2'b00, 0);
        cyc(0, 1, 1, 1, 1,  9, 0,  3, 0, RF0, RF1, 2'b00, 0);
        cyc(0, 1, 0, 0, 0,  0, 0,  3, 9, RF0, RF1, 2'b00, 0);
        // Non-ready match without a decode instruction: no stall.
        cyc(0, 1, 0, 1, 1,  3, 1,  0, 0, RF0, RF1, 2'b00, 0);
        cyc(0, 1, 0, 0, 0,  0, 0,  3, 0, RF0, RF1, 2'b00, 0);
        cyc(0, 1, 0, 0, 0,  0, 0,  0, 3, RF0, S1,  2'b10, 0);
        cyc(0, 1, 0, 0, 0,  0, 0,  0, 0, RF0, RF1, 2'b00, 0);
        // Hold with advance=0 for 5 cycles.
        cyc(0, 1, 0, 1, 1,  6, 0,  0, 0, RF0, RF1, 2'b00, 0);
        cyc(0, 1, 0, 1, 1,  7, 0,  0, 0, RF0, RF1, 2'b00, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 1, 1, 10, 0, 7, 6, S0, S1, 2'b11, 0);
        end
        // Flush without advance kills only the EX entry.
        cyc(0, 0, 1, 1, 1, 10, 0,  7, 6, S0,  S1,  2'b11, 0);
        cyc(0, 0, 0, 1, 1, 10, 0,  7, 6, RF0, S1,  2'b10, 0);
        // Write to $0 is never tracked; rsel=0 never hits.
        cyc(0, 1, 0, 1, 1,  0, 0,  0, 6, RF0, S1,  2'b10, 0);
        cyc(0, 1, 0, 0, 0,  0, 0,  0, 6, RF0, S2,  2'b10, 0);
        // Mid-run reset clears live entries.
        cyc(0, 1, 0, 1, 1,  5, 0,  0, 0, RF0, RF1, 2'b00, 0);
        cyc(1, 1, 0, 1, 1,  5, 0,  5, 0, S0,  RF1, 2'b01, 0);
        cyc(0, 1, 0, 0, 0,  0, 0,  5, 5, RF0, RF1, 2'b00, 0);

        @(posedge clk);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised successor to the fixed two-operand forwarding unit for the pipelined CPU.
- Tracks in-flight register writes across DEPTH post-decode stages (EX, MEM, WB at default) in a registered shift structure.
- Resolves NRD decode read ports against the tracked writes, selecting the youngest ready producer or the register file value.
- Raises a load-use stall when the matching producer's data is not yet available; sits beside the decode stage and drives operand muxes and the hazard path.

Parameters:
- NREGS, 32, number of architectural registers; register 0 is hardwired zero.
- REG_W, $clog2(NREGS), register select width.
- WORD_W, 32, datapath word width.
- DEPTH, 3, tracked stages; index 0 = EX (youngest), DEPTH-1 = WB (oldest).
- NRD, 2, number of decode read ports.
- LD_STAGE, 1, first stage index at which a load result is valid in stage_data; range 0..DEPTH-1.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- advance  in  1  pipeline moves this cycle (ihit/dhit qualified).
- flush  in  1  squash youngest tracked entry and the issuing instruction.
- issue_valid  in  1  decode instruction present.
- issue_wen  in  1  decode instruction writes a register.
- issue_wsel  in  REG_W  decode destination register.
- issue_ld  in  1  decode instruction is a load.
- rsel  in  NRD*REG_W  read selects, port p at [p*REG_W +: REG_W].
- rf_data  in  NRD*WORD_W  register file read data per port.
- stage_data  in  DEPTH*WORD_W  result value held in each tracked stage.
- fwd_data  out  NRD*WORD_W  resolved operand per port.
- fwd_hit  out  NRD  port p resolved from stage_data.
- stall  out  1  hold decode and insert a bubble into EX.

Behaviour:
- State: entry e[k], k=0..DEPTH-1, with fields {valid, wsel, ld}; all registered.
- Reset: all e[k].valid=0, so stall=0, fwd_hit=0, fwd_data=rf_data.
- Reset wins over advance and flush in the same cycle.
- Entry readiness: e[k] is ready iff !e[k].ld or k>=LD_STAGE.
- Capture qualifier: new = issue_valid & issue_wen & (issue_wsel!=0).
- Update on advance=1, flush=0, stall=0:
  - e[0] <= {new, issue_wsel, issue_ld}.
  - e[k] <= e[k-1] for k>=1; e[DEPTH-1] retires.
- Update on advance=1, stall=1: e[0] <= bubble (valid=0); older entries shift as above.
- Update on advance=1, flush=1:
  - e[0] <= bubble and e[1] <= bubble (old e[0] squashed).
  - e[k] <= e[k-1] for k>=2.
  - If DEPTH==1: e[0] <= bubble.
- Update on advance=0: all entries hold.
- Update on advance=0, flush=1: e[0].valid <= 0; others hold.
- Resolution per port p (combinational from registered entries plus inputs; zero latency):
  - If rsel_p==0: fwd_data=rf_data_p, hit=0.
  - Otherwise find the lowest k with e[k].valid and e[k].wsel==rsel_p; the youngest producer wins over older ones.
  - Match and ready: fwd_data_p=stage_data[k], fwd_hit_p=1.
  - Match and not ready: fwd_data_p=rf_data_p, fwd_hit_p=0, port stall request=1.
  - No match: fwd_data_p=rf_data_p, fwd_hit_p=0.
- stall = OR of port stall requests & issue_valid & !flush.
  - A non-ready match is never bypassed by an older ready match.
- The register file is write-first, or DEPTH includes WB, so retired writes are visible through rf_data.
- Multiple ports matching the same entry each forward independently.

Optional Feature:
- Macro FWD_PERF_EN.
- Defined: adds outputs perf_fwd_cnt (32) and perf_stall_cnt (32), both reset to 0.
  - perf_fwd_cnt +1 each cycle with advance=1 and any fwd_hit bit set.
  - perf_stall_cnt +1 each cycle with advance=1 and stall=1.
  - Both saturate at 32'hFFFFFFFF.
- Undefined: the ports and counters are absent; resolution behaviour is identical.

Test Plan:
- RST=1 for 2 cycles with stale inputs, then issue add to $5 -> during reset stall=0, fwd_hit=0; after reset, next cycle rsel0=5 gives fwd_hit[0]=1 and fwd_data0=stage_data[0].
- Back-to-back writes to $8 (older at k=1 value 0x11, younger at k=0 value 0x22), rsel0=rsel1=8 -> both ports output 0x22, fwd_hit=2'b11.
- Load to $3 issued, next decode reads $3 with LD_STAGE=1 -> stall=1 exactly one advancing cycle and e[0] bubbles; following cycle fwd_data=stage_data[1], stall=0.
- Load-use with flush=1 on the same cycle -> stall=0; the load and the issuing instruction are squashed; rsel=3 next cycle has no hit.
- advance=0 for 5 cycles with entries valid -> entries hold and outputs stay constant; write to $0 issued -> never tracked, rsel=0 always hit=0.
- FWD_PERF_EN with counters preloaded near saturation by 3 stall cycles -> perf_stall_cnt holds at 32'hFFFFFFFF.
